// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for register_file: clears every register after
// reset, then round-robin arbitrates NREQ requesters onto the one port.
module regfile_write_arbiter #(
  parameter int NREGS = 8,
  parameter int RSIZE = 8,
  parameter int NREQ  = 4,
  localparam int IW   = $clog2(NREGS),
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*IW-1:0]    req_idx_i,
  input  logic [NREQ*RSIZE-1:0] req_data_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  w_o,
  output logic [IW-1:0]         widx_o,
  output logic [RSIZE-1:0]      wd_o,
  output logic                  init_done_o
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_cnt;
  logic [PW-1:0]   r_rr;

  logic [PW-1:0]   w_hi;
  logic [PW-1:0]   w_lo;
  logic            w_hi_ok;
  logic            w_lo_ok;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_rr_nxt;
  logic            w_run;
  logic [NREQ-1:0] w_gnt;

  assign w_run = (r_state == S_RUN);

  // Lowest requester at/above rr_ptr wins; else wrap to lowest overall.
  always_comb begin
    w_hi    = '0;
    w_lo    = '0;
    w_hi_ok = 1'b0;
    w_lo_ok = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        w_lo    = PW'(k);
        w_lo_ok = 1'b1;
        if (PW'(k) >= r_rr) begin
          w_hi    = PW'(k);
          w_hi_ok = 1'b1;
        end
      end
    end
  end

  assign w_win    = w_hi_ok ? w_hi : w_lo;
  assign w_rr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  assign w_gnt = (w_run && w_lo_ok) ? (NREQ'(1) << w_win) : '0;
  assign gnt_o = w_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_rr        <= '0;
      w_o         <= 1'b0;
      widx_o      <= '0;
      wd_o        <= '0;
      init_done_o <= 1'b0;
    end else begin
      unique case (r_state)
        S_INIT: begin
          w_o    <= 1'b1;
          widx_o <= r_cnt;
          wd_o   <= '0;
          if (r_cnt == IW'(NREGS - 1)) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            init_done_o <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          w_o <= w_lo_ok;
          if (w_lo_ok) begin
            widx_o <= req_idx_i[w_win*IW +: IW];
            wd_o   <= req_data_i[w_win*RSIZE +: RSIZE];
            r_rr   <= w_rr_nxt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: reference model + scoreboard on the
// write port, table of arbitration vectors, hand-written reset sequences.
module tb_regfile_write_arbiter;

  localparam int NREGS = 8;
  localparam int RSIZE = 8;
  localparam int NREQ  = 4;
  localparam int IW    = 3;

  typedef struct {
    logic             w;
    logic [IW-1:0]    idx;
    logic [RSIZE-1:0] data;
    logic             done;
  } exp_t;

  typedef struct {
    logic [NREQ-1:0]       req;
    logic [NREQ*IW-1:0]    idx;
    logic [NREQ*RSIZE-1:0] data;
    logic [NREQ-1:0]       gnt;
  } vec_t;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [NREQ-1:0]       req_i = '0;
  logic [NREQ*IW-1:0]    req_idx_i = '0;
  logic [NREQ*RSIZE-1:0] req_data_i = '0;
  logic [NREQ-1:0]       gnt_o;
  logic                  w_o;
  logic [IW-1:0]         widx_o;
  logic [RSIZE-1:0]      wd_o;
  logic                  init_done_o;

  int checks = 0;
  int errors = 0;

  exp_t sbq[$];
  bit   sb_en = 1'b0;

  bit               m_run;
  int               m_cnt;
  int               m_rr;
  logic [IW-1:0]    m_idx;
  logic [RSIZE-1:0] m_data;
  int               m_win;
  int               m_k;
  logic [NREQ-1:0]  m_gnt;
  exp_t             m_e;

  logic [RSIZE-1:0] mem [NREGS];

  vec_t tbl [16];

  regfile_write_arbiter #(
    .NREGS(NREGS),
    .RSIZE(RSIZE),
    .NREQ (NREQ)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .req_idx_i  (req_idx_i),
    .req_data_i (req_data_i),
    .gnt_o      (gnt_o),
    .w_o        (w_o),
    .widx_o     (widx_o),
    .wd_o       (wd_o),
    .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  // register_file stand-in
  always @(posedge clk_i) begin
    if (w_o) mem[widx_o] <= wd_o;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_e(input logic w, input logic [IW-1:0] i,
                                input logic [RSIZE-1:0] d,
                                input logic dn);
    exp_t e;
    e.w = w;
    e.idx = i;
    e.data = d;
    e.done = dn;
    return e;
  endfunction

  function automatic vec_t mk_v(input logic [NREQ-1:0] r,
                                input logic [NREQ*IW-1:0] i,
                                input logic [NREQ*RSIZE-1:0] d,
                                input logic [NREQ-1:0] g);
    vec_t v;
    v.req = r;
    v.idx = i;
    v.data = d;
    v.gnt = g;
    return v;
  endfunction

  // Scoreboard: check last edge's outputs, then predict the next edge.
  always @(negedge clk_i) begin
    if (sb_en) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got none expected entry");
      end else begin
        m_e = sbq.pop_front();
        chk("sb_w", 32'(w_o), 32'(m_e.w));
        chk("sb_done", 32'(init_done_o), 32'(m_e.done));
        if (m_e.w) begin
          chk("sb_widx", 32'(widx_o), 32'(m_e.idx));
          chk("sb_wd", 32'(wd_o), 32'(m_e.data));
        end
      end
      m_win = -1;
      m_gnt = '0;
      if (m_run) begin
        for (int j = 0; j < NREQ; j++) begin
          m_k = (m_rr + j) % NREQ;
          if (m_win < 0 && req_i[m_k]) m_win = m_k;
        end
      end
      if (m_win >= 0) m_gnt[m_win] = 1'b1;
      chk("sb_gnt", 32'(gnt_o), 32'(m_gnt));
      if (!m_run) begin
        m_idx  = IW'(m_cnt);
        m_data = '0;
        sbq.push_back(mk_e(1'b1, m_idx, m_data, m_cnt == NREGS - 1));
        if (m_cnt == NREGS - 1) begin
          m_run = 1'b1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else if (m_win >= 0) begin
        m_idx  = req_idx_i[m_win*IW +: IW];
        m_data = req_data_i[m_win*RSIZE +: RSIZE];
        m_rr   = (m_win + 1) % NREQ;
        sbq.push_back(mk_e(1'b1, m_idx, m_data, 1'b1));
      end else begin
        sbq.push_back(mk_e(1'b0, m_idx, m_data, 1'b1));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [NREQ-1:0] r,
                       input logic [NREQ*IW-1:0] i,
                       input logic [NREQ*RSIZE-1:0] d);
    req_i      = r;
    req_idx_i  = i;
    req_data_i = d;
  endtask

  // Called just after a rising edge; asserts reset mid-cycle.
  task automatic do_reset();
    sb_en  = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_w", 32'(w_o), 32'd0);
    chk("rst_widx", 32'(widx_o), 32'd0);
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_done", 32'(init_done_o), 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    m_run  = 1'b0;
    m_cnt  = 0;
    m_rr   = 0;
    m_idx  = '0;
    m_data = '0;
    sbq.delete();
    sbq.push_back(mk_e(1'b0, '0, '0, 1'b0));
    tick();
    rst_ni = 1'b1;
    sb_en  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ*IW-1:0]    i0;
    logic [NREQ*RSIZE-1:0] d0;
    logic [NREQ*IW-1:0]    i5;
    logic [NREQ*RSIZE-1:0] d5;
    i0 = {3'd3, 3'd2, 3'd1, 3'd0};
    d0 = {8'd3, 8'd2, 8'd1, 8'd0};
    i5 = {3'd5, 3'd5, 3'd5, 3'd5};
    d5 = {8'd0, 8'd22, 8'd11, 8'd0};
    tbl[0]  = mk_v(4'b1111, i0, d0, 4'b0001);
    tbl[1]  = mk_v(4'b1111, i0, d0, 4'b0010);
    tbl[2]  = mk_v(4'b1111, i0, d0, 4'b0100);
    tbl[3]  = mk_v(4'b1111, i0, d0, 4'b1000);
    tbl[4]  = mk_v(4'b1111, i0, d0, 4'b0001);
    tbl[5]  = mk_v(4'b0100, i0, d0, 4'b0100);
    tbl[6]  = mk_v(4'b1001, i0, d0, 4'b1000);
    tbl[7]  = mk_v(4'b0001, i0, d0, 4'b0001);
    tbl[8]  = mk_v(4'b0000, i0, d0, 4'b0000);
    tbl[9]  = mk_v(4'b0110, i5, d5, 4'b0010);
    tbl[10] = mk_v(4'b0100, i5, d5, 4'b0100);
    tbl[11] = mk_v(4'b0000, i5, d5, 4'b0000);
    tbl[12] = mk_v(4'b0000, i5, d5, 4'b0000);
    tbl[13] = mk_v(4'b1000, i0, d0, 4'b1000);
    tbl[14] = mk_v(4'b0010, i0, d0, 4'b0010);
    tbl[15] = mk_v(4'b0011, i0, d0, 4'b0001);

    tick();

    // Clear sequence with no requests
    do_reset();
    repeat (8) tick();
    chk("s1_done", 32'(init_done_o), 32'd1);
    chk("s1_widx7", 32'(widx_o), 32'd7);
    tick();
    chk("s1_idle_w", 32'(w_o), 32'd0);

    // Request held from reset release
    drive(4'b0001, {9'd0, 3'd3}, {24'd0, 8'hA5});
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("s2_init_gnt", 32'(gnt_o), 32'd0);
      tick();
    end
    chk("s2_gnt", 32'(gnt_o), 32'b0001);
    tick();
    drive('0, '0, '0);
    chk("s2_w", 32'(w_o), 32'd1);
    chk("s2_widx", 32'(widx_o), 32'd3);
    chk("s2_wd", 32'(wd_o), 32'hA5);
    tick();
    chk("s2_mem3", 32'(mem[3]), 32'hA5);

    // Arbitration vectors from a fresh rr_ptr=0
    do_reset();
    repeat (8) tick();
    for (int r = 0; r < 16; r++) begin
      drive(tbl[r].req, tbl[r].idx, tbl[r].data);
      #3;
      chk($sformatf("tbl_gnt[%0d]", r), 32'(gnt_o), 32'(tbl[r].gnt));
      tick();
      if (r == 12) chk("s5_mem5", 32'(mem[5]), 32'd22);
    end
    drive('0, '0, '0);
    tick();

    // Reset during clear sequence
    do_reset();
    repeat (4) tick();
    chk("s6_pre_widx", 32'(widx_o), 32'd3);
    do_reset();
    tick();
    chk("s6_w", 32'(w_o), 32'd1);
    chk("s6_widx0", 32'(widx_o), 32'd0);
    repeat (6) tick();
    chk("s6_notdone", 32'(init_done_o), 32'd0);
    tick();
    chk("s6_done", 32'(init_done_o), 32'd1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
